bin_step_counter: RTL and testbench

- Upstream value source for the binary-to-decimal 7-segment display stage.
- Turns a raw, bouncing active-low pushbutton into clean single steps of a 4-bit up/down counter. Supports parallel load.
- Output V[3:0] drives the converter's 4-bit binary input directly. Range is 0..MAX_VAL, with wrap-around in both directions.

---
 rtl/bin_disp_pkg.sv | 17 +
 rtl/key_debounce.sv | 78 +++++++
 rtl/bin_step_counter.sv | 105 ++++++++++
 tb/tb_bin_step_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_disp_pkg.sv
// Shared definitions for the binary-to-decimal display path: debounce FSM
// encoding and default width/count/cycle constants.
package bin_disp_pkg;

    localparam int unsigned DISP_WIDTH          = 4;
    localparam int unsigned DISP_MAX_VAL        = 15;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_AUTO_DIV        = 50000000;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PRESS_WAIT = 2'b01,
        HELD       = 2'b10,
        REL_WAIT   = 2'b11
    } deb_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus press/release debounce FSM for an active-low key;
// emits a one-cycle combinational pulse when a press has been stable long enough.
module key_debounce
    import bin_disp_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLOCK_50,
    input  logic RESETN,
    input  logic KEY_N,
    output logic step_c
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          ks;
    deb_state_e    state;
    deb_state_e    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Reset lands in HELD so a key held through reset must be released first.
    always_ff @(posedge CLOCK_50) begin
        if (!RESETN) begin
            sync1 <= 1'b1;
            ks    <= 1'b1;
            state <= HELD;
            cnt   <= '0;
        end else begin
            sync1 <= KEY_N;
            ks    <= sync1;
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        step_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!ks) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (ks) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                    step_c     = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HELD: begin
                if (ks) begin
                    state_next = REL_WAIT;
                    cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (!ks) begin
                    state_next = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/bin_step_counter.sv
// Debounced up/down step counter with parallel load feeding the display converter.
// Optional auto-step prescaler is built when AUTO_STEP_EN is defined.
module bin_step_counter
    import bin_disp_pkg::*;
#(
    parameter int unsigned WIDTH           = DISP_WIDTH,
    parameter int unsigned MAX_VAL         = DISP_MAX_VAL,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned AUTO_DIV        = DEF_AUTO_DIV
) (
    input  logic             CLOCK_50,
    input  logic             RESETN,
    input  logic             KEY_N,
    input  logic             SW_DIR,
    input  logic             SW_LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             SW_AUTO,
    output logic [WIDTH-1:0] V,
    output logic             STEP,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] VMAX = WIDTH'(MAX_VAL);

    logic             key_step_c;
    logic             step_c;
    logic [WIDTH-1:0] v_next_c;
    logic             wrap_c;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .CLOCK_50(CLOCK_50),
        .RESETN  (RESETN),
        .KEY_N   (KEY_N),
        .step_c  (key_step_c)
    );

`ifdef AUTO_STEP_EN
    localparam int unsigned PW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    logic [PW-1:0] pre;
    logic          tick_c;

    assign tick_c = SW_AUTO && (pre == PW'(AUTO_DIV - 1));

    // Prescaler restarts whenever auto mode is off or a load is in progress.
    always_ff @(posedge CLOCK_50) begin
        if (!RESETN || !SW_AUTO || SW_LOAD) begin
            pre <= '0;
        end else if (tick_c) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    assign step_c = key_step_c | tick_c;
`else
    logic unused_auto;
    assign unused_auto = SW_AUTO;
    assign step_c      = key_step_c;
`endif

    always_comb begin
        v_next_c = V;
        wrap_c   = 1'b0;
        if (SW_DIR) begin
            if (V == '0) begin
                v_next_c = VMAX;
                wrap_c   = 1'b1;
            end else begin
                v_next_c = V - WIDTH'(1);
            end
        end else begin
            if (V == VMAX) begin
                v_next_c = '0;
                wrap_c   = 1'b1;
            end else begin
                v_next_c = V + WIDTH'(1);
            end
        end
    end

    // Load wins over any step arriving in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!RESETN) begin
            V    <= '0;
            STEP <= 1'b0;
            WRAP <= 1'b0;
        end else if (SW_LOAD) begin
            V    <= (LOAD_VAL > VMAX) ? VMAX : LOAD_VAL;
            STEP <= 1'b0;
            WRAP <= 1'b0;
        end else if (step_c) begin
            V    <= v_next_c;
            STEP <= 1'b1;
            WRAP <= wrap_c;
        end else begin
            STEP <= 1'b0;
            WRAP <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin_step_counter.sv
// Bench for bin_step_counter: two instances (MAX_VAL 15 and 9) checked every cycle
// against a run-length based behavioural model, plus directed spot checks.
module tb_bin_step_counter;

    localparam int unsigned D    = 4;
    localparam int unsigned ADIV = 8;

    logic       clk;
    logic       rstn;
    logic       key;
    logic       dir;
    logic       load;
    logic [3:0] lval;
    logic       auto_en;
    logic [3:0] v15, v9;
    logic       step15, step9, wrap15, wrap9;

    int ncmp  = 0;
    int nfail = 0;

    bin_step_counter #(.WIDTH(4), .MAX_VAL(15), .DEBOUNCE_CYCLES(D), .AUTO_DIV(ADIV)) dut (
        .CLOCK_50(clk), .RESETN(rstn), .KEY_N(key), .SW_DIR(dir), .SW_LOAD(load),
        .LOAD_VAL(lval), .SW_AUTO(auto_en), .V(v15), .STEP(step15), .WRAP(wrap15)
    );

    bin_step_counter #(.WIDTH(4), .MAX_VAL(9), .DEBOUNCE_CYCLES(D), .AUTO_DIV(ADIV)) dut9 (
        .CLOCK_50(clk), .RESETN(rstn), .KEY_N(key), .SW_DIR(dir), .SW_LOAD(load),
        .LOAD_VAL(lval), .SW_AUTO(auto_en), .V(v9), .STEP(step9), .WRAP(wrap9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit s1, s2, prev_ks, pressed;
    int run, pre;
    int mv[2], mstep[2], mwrap[2];
    int maxv[2] = '{15, 9};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit ks, kstep, tick;
        int rn;
        if (!rstn) begin
            s1 = 1; s2 = 1; run = 0; pressed = 1; pre = 0;
            for (int i = 0; i < 2; i++) begin
                mv[i] = 0; mstep[i] = 0; mwrap[i] = 0;
            end
        end else begin
            ks = s2;
            rn = (run == 0 || ks != prev_ks) ? 1 : run + 1;
            kstep = 0;
            // A level must persist D+1 synchronized samples to be accepted.
            if (!pressed && !ks && rn == int'(D) + 1) begin
                kstep = 1;
                pressed = 1;
            end else if (pressed && ks && rn == int'(D) + 1) begin
                pressed = 0;
            end
            prev_ks = ks;
            run = rn;
`ifdef AUTO_STEP_EN
            tick = auto_en && (pre == int'(ADIV) - 1);
            if (!auto_en || load) pre = 0;
            else pre = (pre + 1) % int'(ADIV);
`else
            tick = 0;
`endif
            for (int i = 0; i < 2; i++) begin
                if (load) begin
                    mv[i] = (int'(lval) > maxv[i]) ? maxv[i] : int'(lval);
                    mstep[i] = 0; mwrap[i] = 0;
                end else if (kstep || tick) begin
                    mstep[i] = 1;
                    if (!dir) begin
                        mwrap[i] = (mv[i] == maxv[i]);
                        mv[i] = mwrap[i] ? 0 : mv[i] + 1;
                    end else begin
                        mwrap[i] = (mv[i] == 0);
                        mv[i] = mwrap[i] ? maxv[i] : mv[i] - 1;
                    end
                end else begin
                    mstep[i] = 0; mwrap[i] = 0;
                end
            end
            s2 = s1;
            s1 = key;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("v15",    32'(v15),    32'(mv[0]));
        chk("step15", 32'(step15), 32'(mstep[0]));
        chk("wrap15", 32'(wrap15), 32'(mwrap[0]));
        chk("v9",     32'(v9),     32'(mv[1]));
        chk("step9",  32'(step9),  32'(mstep[1]));
        chk("wrap9",  32'(wrap9),  32'(mwrap[1]));
    endtask

    task automatic press();
        key = 1'b0;
        repeat (10) cyc();
        key = 1'b1;
        repeat (10) cyc();
    endtask

    task automatic do_load(input logic [3:0] val);
        lval = val;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; key = 1'b1; dir = 1'b0; load = 1'b0; lval = '0; auto_en = 1'b0;
        repeat (2) cyc();
        chk("rst_v", 32'(v15), 32'd0);
        chk("rst_step", 32'(step15), 32'd0);
        rstn = 1'b1;
        repeat (8) cyc();

        // Clean press: step lands exactly 7 edges after the first low sample
        key = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 6) chk("lat_early", 32'(v15), 32'd0);
            if (k == 7) begin
                chk("lat_v", 32'(v15), 32'd1);
                chk("lat_step", 32'(step15), 32'd1);
            end
        end
        chk("held_norepeat", 32'(v15), 32'd1);
        key = 1'b1;
        repeat (10) cyc();

        // Bounce shorter than the debounce window
        repeat (2) begin
            key = 1'b0; repeat (2) cyc();
            key = 1'b1; repeat (2) cyc();
        end
        repeat (10) cyc();
        chk("bounce_v", 32'(v15), 32'd1);

        // Wrap up then down
        do_load(4'd15);
        dir = 1'b0;
        press();
        chk("wrap_up_v", 32'(v15), 32'd0);
        dir = 1'b1;
        press();
        chk("wrap_dn_v", 32'(v15), 32'd15);
        chk("wrap_dn_v9", 32'(v9), 32'd9);

        // Loads, clamping, and load colliding with the step pulse
        do_load(4'd9);
        chk("load9", 32'(v15), 32'd9);
        do_load(4'd13);
        chk("clamp9", 32'(v9), 32'd9);
        chk("noclamp15", 32'(v15), 32'd13);
        dir = 1'b0;
        key = 1'b0;
        repeat (6) cyc();
        lval = 4'd5;
        load = 1'b1;
        cyc();
        chk("load_pulse_v", 32'(v15), 32'd5);
        chk("load_pulse_step", 32'(step15), 32'd0);
        load = 1'b0;
        repeat (10) cyc();
        key = 1'b1;
        repeat (10) cyc();

        // Key held through reset
        key = 1'b0;
        repeat (3) cyc();
        rstn = 1'b0;
        repeat (2) cyc();
        rstn = 1'b1;
        repeat (30) cyc();
        chk("held_rst_v", 32'(v15), 32'd0);
        key = 1'b1;
        repeat (10) cyc();
        press();
        chk("after_rel_v", 32'(v15), 32'd1);

        // Auto-step enabled then disabled
        dir = 1'b0;
        auto_en = 1'b1;
        repeat (40) cyc();
        auto_en = 1'b0;
        repeat (20) cyc();

        // Randomized segments
        for (int seg = 0; seg < 120; seg++) begin
            int mode;
            mode = int'($urandom_range(0, 19));
            if (mode == 0) begin
                rstn = 1'b0;
                repeat (2) cyc();
                rstn = 1'b1;
            end else if (mode <= 3) begin
                do_load(4'($urandom_range(0, 15)));
            end else begin
                key = 1'($urandom_range(0, 1));
                dir = 1'($urandom_range(0, 1));
                auto_en = ($urandom_range(0, 5) == 0);
                repeat ($urandom_range(1, 12)) cyc();
            end
        end
        auto_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
